// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - fetch and data-memory handshake bundle for control_sequencer
interface control_sequencer_if #(
    parameter int INSTR_W = 16
);
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready;
    logic               ifetch_req;
    logic               mem_ready;
    logic               mem_read_en;
    logic               mem_write_en;

    modport master (
        input  imem_rdata, imem_ready, mem_ready,
        output ifetch_req, mem_read_en, mem_write_en
    );

    modport slave (
        output imem_rdata, imem_ready, mem_ready,
        input  ifetch_req, mem_read_en, mem_write_en
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle control FSM; optional interrupt entry under CTRL_SEQ_IRQ_EN
module control_sequencer #(
    parameter int INSTR_W     = 16,
    parameter int REG_ADDR_W  = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    control_sequencer_if.master   bus,
    input  logic [7:0]            flags,
    input  logic                  irq_req,
    output logic [3:0]            alu_op,
    output logic [REG_ADDR_W-1:0] reg_addr_a,
    output logic [REG_ADDR_W-1:0] reg_addr_b,
    output logic [REG_ADDR_W-1:0] reg_addr_w,
    output logic                  reg_write_en,
    output logic                  pc_inc,
    output logic                  pc_write_en,
    output logic                  sp_inc,
    output logic                  sp_dec,
    output logic                  flags_we,
    output logic                  irq_ack,
    output logic                  halted,
    output logic                  bus_err,
    output logic                  retire,
    output logic [2:0]            state_o
);
    localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] TO_VAL = WCW'(MEM_TIMEOUT);
    localparam bit TO_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_MEMORY = 3'd3,
        S_WRITEBACK = 3'd4, S_INTERRUPT = 3'd5, S_HALT = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [WCW-1:0]     wait_cnt_q, wait_cnt_d;
    logic               bus_err_q, bus_err_d;
    logic               ifetch_req, mem_read_en, mem_write_en;

    logic [3:0] op;
    logic [2:0] fn;
    assign op         = ir_q[INSTR_W-1 -: 4];
    assign fn         = ir_q[2:0];
    assign reg_addr_a = ir_q[INSTR_W-5 -: REG_ADDR_W];
    assign reg_addr_b = ir_q[INSTR_W-5-REG_ADDR_W -: REG_ADDR_W];
    assign reg_addr_w = reg_addr_a;

    // Instruction classes: op4 fn{LOAD,LOADR,STORE,STORER,LOADI}, op6 fn{PUSH,POP,CALL,RET}
    logic is_alu, is_cmp, is_br, is_halt, is_load, is_store, is_loadi;
    logic is_push, is_pop, is_call, is_ret, mem_rd, mem_wr, writes_reg, br_taken;
    assign is_alu     = (op <= 4'd3);
    assign is_cmp     = (op == 4'd8);
    assign is_br      = (op == 4'd5);
    assign is_halt    = (op == 4'd7) && (fn == 3'd4);
    assign is_load    = (op == 4'd4) && (fn == 3'd0 || fn == 3'd1);
    assign is_store   = (op == 4'd4) && (fn == 3'd2 || fn == 3'd3);
    assign is_loadi   = (op == 4'd4) && (fn == 3'd4);
    assign is_push    = (op == 4'd6) && (fn == 3'd0);
    assign is_pop     = (op == 4'd6) && (fn == 3'd1);
    assign is_call    = (op == 4'd6) && (fn == 3'd2);
    assign is_ret     = (op == 4'd6) && (fn == 3'd3);
    assign mem_rd     = is_load | is_pop | is_ret;
    assign mem_wr     = is_store | is_push | is_call;
    assign writes_reg = is_alu | is_load | is_loadi | is_pop;

    // Branch condition select; flags bit0 C, 1 Z, 2 N, 3 V
    always_comb begin
        br_taken = 1'b0;
        case (fn)
            3'd0: br_taken = 1'b1;
            3'd1: br_taken = flags[1];
            3'd2: br_taken = ~flags[1];
            3'd3: br_taken = flags[2];
            3'd4: br_taken = ~flags[2];
            3'd5: br_taken = flags[0];
            3'd6: br_taken = ~flags[0];
            default: br_taken = flags[3];
        endcase
    end

    // ALU op map: ADD 0, SUB 1, ADC 2, SBC 3, AND..NOT 4-7, SHL..ROR 8-B, CMP C, PASS D
    always_comb begin
        alu_op = 4'hD;
        case (op)
            4'd0: alu_op = 4'h0;
            4'd1: alu_op = (fn[1:0] == 2'd0) ? 4'h1 : {2'b00, fn[1:0]};
            4'd2: alu_op = {2'b01, fn[1:0]};
            4'd3: alu_op = {2'b10, fn[1:0]};
            4'd8: alu_op = 4'hC;
            default: alu_op = 4'hD;
        endcase
    end

    // Next state and per-state strobes; rst forces every strobe low in its own cycle
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        wait_cnt_d   = wait_cnt_q;
        bus_err_d    = bus_err_q;
        ifetch_req   = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        reg_write_en = 1'b0;
        pc_inc       = 1'b0;
        pc_write_en  = 1'b0;
        sp_inc       = 1'b0;
        sp_dec       = 1'b0;
        flags_we     = 1'b0;
        irq_ack      = 1'b0;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    ifetch_req = 1'b1;
                    ir_d       = bus.imem_rdata;
                    pc_inc     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_DECODE;
                end else if (TO_EN && wait_cnt_q == TO_VAL) begin
                    bus_err_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_HALT;
                end else begin
                    ifetch_req = 1'b1;
                    if (TO_EN) wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                flags_we    = is_alu | is_cmp;
                pc_write_en = is_br & br_taken;
                sp_dec      = is_push | is_call;
                if (mem_rd || mem_wr) begin
                    state_d = S_MEMORY;
                end else if (is_halt) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (bus.mem_ready) begin
                    mem_read_en  = mem_rd;
                    mem_write_en = mem_wr;
                    sp_inc       = is_pop | is_ret;
                    pc_write_en  = is_call | is_ret;
                    wait_cnt_d   = '0;
                    state_d      = S_WRITEBACK;
                end else if (TO_EN && wait_cnt_q == TO_VAL) begin
                    bus_err_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_HALT;
                end else begin
                    mem_read_en  = mem_rd;
                    mem_write_en = mem_wr;
                    if (TO_EN) wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_WRITEBACK: begin
                reg_write_en = writes_reg;
                retire       = 1'b1;
                state_d      = S_FETCH;
`ifdef CTRL_SEQ_IRQ_EN
                if (irq_req && flags[4]) state_d = S_INTERRUPT;
`endif
            end
            S_INTERRUPT: begin
`ifdef CTRL_SEQ_IRQ_EN
                irq_ack      = 1'b1;
                sp_dec       = 1'b1;
                mem_write_en = 1'b1;
                pc_write_en  = 1'b1;
                flags_we     = 1'b1;
`endif
                state_d = S_FETCH;
            end
            S_HALT: begin
`ifdef CTRL_SEQ_IRQ_EN
                if (!bus_err_q && irq_req && flags[4]) state_d = S_INTERRUPT;
`endif
            end
            default: state_d = S_FETCH;
        endcase
        halted = (state_q == S_HALT);
        if (rst) begin
            ifetch_req   = 1'b0;
            mem_read_en  = 1'b0;
            mem_write_en = 1'b0;
            reg_write_en = 1'b0;
            pc_inc       = 1'b0;
            pc_write_en  = 1'b0;
            sp_inc       = 1'b0;
            sp_dec       = 1'b0;
            flags_we     = 1'b0;
            irq_ack      = 1'b0;
            retire       = 1'b0;
            halted       = 1'b0;
        end
    end

    // State, instruction, wait counter and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus.ifetch_req   = ifetch_req;
    assign bus.mem_read_en  = mem_read_en;
    assign bus.mem_write_en = mem_write_en;
    assign bus_err          = bus_err_q;
    assign state_o          = state_q;

    logic unused_bits;
    assign unused_bits = ^{flags[7:4], irq_req, ir_q};
endmodule
